bus_interconnect: RTL and testbench

//   Parametrised memory-mapped bus decoder/arbiter between the single-cycle CPU data port and NS slaves (RAM, display, I/O).

---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_addr_decode.sv | 40 ++++
 rtl/bus_interconnect.sv | 188 ++++++++++++++++++
 tb/tb_bus_interconnect.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared declarations for the CPU data-port bus interconnect:
//     - bus_state_t   : interconnect FSM states
//     - BUS_ERR_DATA  : default read data returned with an error response
//     - slot()        : extracts element i of a packed array of w-bit slots
//   No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    // Widest slot and widest packed vector slot() can handle
    // (8 slaves, up to 64-bit address/data fields).
    localparam int SLOT_MAX_W = 64;
    localparam int SLOT_VEC_W = 8 * SLOT_MAX_W;

    // Returns slot i of a packed vector built from w-bit slots (slot 0 in the
    // LSBs). Bits above w in the result belong to the next slot; callers
    // truncate the result to w bits.
    function automatic logic [SLOT_MAX_W-1:0] slot(
        input logic [SLOT_VEC_W-1:0] vec,
        input int                    i,
        input int                    w
    );
        logic [SLOT_VEC_W-1:0] shifted;
        shifted = vec >> (i * w);
        return shifted[SLOT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// ---------------------------------------------------------------------------
// bus_addr_decode
//   Combinational address decoder. Slave i is hit when
//   (addr & MASK_i) == BASE_i. When windows overlap the lowest index wins.
// Ports:
//   i_addr  in   AW    byte address to decode
//   o_sel   out  SELW  index of the selected slave (0 when no hit)
//   o_hit   out  1     1 = address falls inside at least one window
// ---------------------------------------------------------------------------
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int              AW   = 32,
    parameter int              NS   = 2,
    parameter int              SELW = 1,
    parameter logic [NS*AW-1:0] BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0] MASK = {32'hFFFF_FFFF, 32'hFFFF_0000}
) (
    input  logic [AW-1:0]   i_addr,
    output logic [SELW-1:0] o_sel,
    output logic            o_hit
);

    localparam logic [SLOT_VEC_W-1:0] BASE_EXT = SLOT_VEC_W'(BASE);
    localparam logic [SLOT_VEC_W-1:0] MASK_EXT = SLOT_VEC_W'(MASK);

    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        // Walk from the highest index down so the lowest matching index is
        // the last assignment and therefore wins.
        for (int i = NS - 1; i >= 0; i--) begin
            if ((i_addr & AW'(slot(MASK_EXT, i, AW))) == AW'(slot(BASE_EXT, i, AW))) begin
                o_hit = 1'b1;
                o_sel = SELW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//   Memory-mapped decoder/arbiter between the single-cycle CPU data port and
//   NS slaves. A request is latched in IDLE, decoded, and forwarded to the
//   selected slave until it acknowledges; the CPU then sees a one-cycle
//   cpu_ack. Unmapped addresses complete with cpu_err and ERR_DATA.
//
//   Optional feature: define BUS_TIMEOUT_EN to add an ack watchdog. A slave
//   that has not acknowledged within TIMEOUT ACCESS cycles is abandoned and
//   the CPU receives the same error response as for an unmapped address.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   cpu_req    in   1      access request, held until cpu_ack
//   cpu_we     in   1      1 = write, 0 = read
//   cpu_addr   in   AW     byte address
//   cpu_wdata  in   DW     write data
//   cpu_ack    out  1      one-cycle completion pulse
//   cpu_err    out  1      valid with cpu_ack; unmapped or timed out
//   cpu_rdata  out  DW     read data, valid with cpu_ack
//   s_en       out  NS     one-hot slave enable, held until that slave acks
//   s_we       out  1      latched cpu_we
//   s_addr     out  AW     latched cpu_addr
//   s_wdata    out  DW     latched cpu_wdata
//   s_rdata    in   NS*DW  packed slave read data, slot i = slave i
//   s_ack      in   NS     slave completion strobes
// ---------------------------------------------------------------------------
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int               AW       = 32,
    parameter int               DW       = 32,
    parameter int               NS       = 2,
    parameter logic [NS*AW-1:0] BASE     = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0] MASK     = {32'hFFFF_FFFF, 32'hFFFF_0000},
    parameter logic [DW-1:0]    ERR_DATA = DW'(BUS_ERR_DATA),
    parameter int               TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_ack,
    output logic             cpu_err,
    output logic [DW-1:0]    cpu_rdata,
    output logic [NS-1:0]    s_en,
    output logic             s_we,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_wdata,
    input  logic [NS*DW-1:0] s_rdata,
    input  logic [NS-1:0]    s_ack
);

    localparam int SELW = (NS > 1) ? $clog2(NS) : 1;

    bus_state_t r_state;
    bus_state_t w_next;

    logic [SELW-1:0] w_sel;
    logic            w_hit;
    logic [SELW-1:0] r_sel;
    logic [NS-1:0]   r_sel_oh;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;

    logic                  w_accept;
    logic                  w_slave_ack;
    logic                  w_expire;
    logic [SLOT_VEC_W-1:0] w_rdata_ext;

    bus_addr_decode #(
        .AW   (AW),
        .NS   (NS),
        .SELW (SELW),
        .BASE (BASE),
        .MASK (MASK)
    ) u_decode (
        .i_addr (cpu_addr),
        .o_sel  (w_sel),
        .o_hit  (w_hit)
    );

    assign w_accept    = (r_state == IDLE) && cpu_req;
    // Only the selected slave may complete the access.
    assign w_slave_ack = |(s_ack & r_sel_oh);
    assign w_rdata_ext = SLOT_VEC_W'(s_rdata);

`ifdef BUS_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] r_cnt;

    // Counts ACCESS cycles already spent; restarts for every access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + CNTW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // True in the TIMEOUT-th ACCESS cycle; a slave ack in that same cycle
    // still takes priority in the next-state logic.
    assign w_expire = (r_state == ACCESS) && (r_cnt == CNTW'(TIMEOUT - 1));
`else
    // No watchdog: the comparison is constant false and folds away.
    assign w_expire = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        s_en    = '0;
        cpu_ack = 1'b0;
        cpu_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    w_next = w_hit ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                s_en = r_sel_oh;
                if (w_slave_ack) begin
                    w_next = RESP;
                end else if (w_expire) begin
                    w_next = ERR;
                end
            end
            RESP: begin
                cpu_ack = 1'b1;
                w_next  = IDLE;
            end
            ERR: begin
                cpu_ack = 1'b1;
                cpu_err = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Request latches and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel    <= '0;
            r_sel_oh <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_sel    <= w_sel;
                r_sel_oh <= w_hit ? (NS'(1) << w_sel) : '0;
                r_we     <= cpu_we;
                r_addr   <= cpu_addr;
                r_wdata  <= cpu_wdata;
            end
            // Writes leave the last read value visible on cpu_rdata.
            if ((r_state == ACCESS) && w_slave_ack && !r_we) begin
                r_rdata <= DW'(slot(w_rdata_ext, int'(r_sel), DW));
            end
        end
    end

    assign s_we      = r_we;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;
    assign cpu_rdata = (r_state == ERR) ? ERR_DATA : r_rdata;

endmodule

// File: tb/tb_bus_interconnect.sv
module tb_bus_interconnect;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 2;
    localparam int TMO = 16;

    logic             clk;
    logic             reset;
    logic             cpu_req;
    logic             cpu_we;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             cpu_ack;
    logic             cpu_err;
    logic [DW-1:0]    cpu_rdata;
    logic [NS-1:0]    s_en;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]    s_ack;

    int checks = 0;
    int errors = 0;

    // Reference address map, one entry per slave.
    logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0001_0000};
    logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_FFFF};
    logic [31:0] m_rdata;   // value cpu_rdata must show outside the error cycle

    bus_interconnect #(
        .AW       (AW),
        .DW       (DW),
        .NS       (NS),
        .BASE     ({32'h0001_0000, 32'h0000_0000}),
        .MASK     ({32'hFFFF_FFFF, 32'hFFFF_0000}),
        .ERR_DATA (32'hDEAD_BEEF),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .s_en      (s_en),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First slave whose window contains addr, or -1 when unmapped.
    function automatic int model_sel(input logic [31:0] addr);
        for (int i = 0; i < NS; i++) begin
            if ((addr & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // One CPU access. Entered at the cycle before the IDLE cycle in which the
    // request is presented. wt = cycles the slave waits after s_en before
    // acking; noise = unselected slaves ack throughout the access.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rd, input int wt, input bit noise);
        int          sel;
        int          ack_cyc;
        bit          exp_err;
        logic [1:0]  sel_oh;
        sel = model_sel(addr);
        sel_oh = (sel >= 0) ? (2'b01 << sel) : 2'b00;
        if (sel < 0) begin
            ack_cyc = 1;
            exp_err = 1'b1;
        end else begin
            ack_cyc = wt + 2;
            exp_err = 1'b0;
`ifdef BUS_TIMEOUT_EN
            if (wt + 1 > TMO) begin
                ack_cyc = TMO + 1;
                exp_err = 1'b1;
            end
`endif
        end

        @(posedge clk); #1;
        chk("idle_sen", 64'(s_en), 64'(0));
        chk("idle_ack", 64'(cpu_ack), 64'(0));
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        s_rdata   = {$urandom, $urandom};
        if (sel >= 0) s_rdata[sel*DW +: DW] = rd;

        for (int c = 1; c <= ack_cyc; c++) begin
            @(posedge clk); #1;
            // CPU inputs must be ignored once the request is latched.
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_we    = 1'($urandom);
            s_ack     = 2'b00;
            if (c < ack_cyc) begin
                chk("acc_sen", 64'(s_en), 64'(sel_oh));
                chk("acc_ack", 64'(cpu_ack), 64'(0));
                chk("acc_addr", 64'(s_addr), 64'(addr));
                chk("acc_we", 64'(s_we), 64'(we));
                chk("acc_wdata", 64'(s_wdata), 64'(wdata));
                if (noise) s_ack = ~sel_oh;
                if (!exp_err && c == ack_cyc - 1) s_ack = s_ack | sel_oh;
            end else begin
                chk("done_ack", 64'(cpu_ack), 64'(1));
                chk("done_err", 64'(cpu_err), 64'(exp_err));
                chk("done_sen", 64'(s_en), 64'(0));
                if (exp_err) begin
                    chk("done_rdata", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
                end else begin
                    if (!we) m_rdata = rd;
                    chk("done_rdata", 64'(cpu_rdata), 64'(m_rdata));
                end
                cpu_req = 1'b0;
            end
        end
        s_ack = 2'b00;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;

        reset     = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        s_rdata   = '0;
        s_ack     = '0;
        m_rdata   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(cpu_ack), 64'(0));
        chk("rst_err", 64'(cpu_err), 64'(0));
        chk("rst_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_sen", 64'(s_en), 64'(0));
        chk("rst_addr", 64'(s_addr), 64'(0));
        chk("rst_wdata", 64'(s_wdata), 64'(0));
        chk("rst_we", 64'(s_we), 64'(0));
        reset = 1'b0;

        // Request low: no slave activity, no ack.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cpu_addr = $urandom;
            chk("noreq_sen", 64'(s_en), 64'(0));
            chk("noreq_ack", 64'(cpu_ack), 64'(0));
        end

        // Directed scenarios.
        txn(1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234, 1, 1'b0);
        txn(1'b1, 32'h0001_0000, 32'hA5, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h0002_0000, 32'h0, 32'h0, 0, 1'b0);
        txn(1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 2, 1'b1);
        txn(1'b0, 32'h0001_0004, 32'h0, 32'h0, 0, 1'b1);

        // Reset in the middle of an access.
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_0200;
        cpu_wdata = 32'h7777_7777;
        @(posedge clk); #1;
        chk("mid_sen", 64'(s_en), 64'(2'b01));
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_sen", 64'(s_en), 64'(0));
        chk("mid_rst_ack", 64'(cpu_ack), 64'(0));
        chk("mid_rst_addr", 64'(s_addr), 64'(0));
        chk("mid_rst_wdata", 64'(s_wdata), 64'(0));
        chk("mid_rst_rdata", 64'(cpu_rdata), 64'(0));
        m_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        txn(1'b0, 32'h0001_0000, 32'h0, 32'hCAFE_0001, 0, 1'b0);

`ifdef BUS_TIMEOUT_EN
        txn(1'b0, 32'h0000_0080, 32'h0, 32'h0, 100, 1'b0);
        txn(1'b0, 32'h0000_0084, 32'h0, 32'h5555_AAAA, TMO - 1, 1'b0);
`endif

        // Randomised accesses across mapped, exact-match and unmapped space.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = 32'h0001_0000;
                2:       a = $urandom;
                default: a = 32'h0001_0000 + 32'($urandom_range(1, 255));
            endcase
            txn(1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
